// File: rtl/mdl_bdoscrgen_pkg.sv
// mdl_bdoscrgen_pkg: shared FSM states, tap selects and checksum width for the BDO scrambler
package mdl_bdoscrgen_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CSUM = 2'd2,
    FIN  = 2'd3
  } state_t;
  localparam logic [1:0] TAP_B7 = 2'b00;
  localparam logic [1:0] TAP_B6 = 2'b01;
  localparam logic [1:0] TAP_B5 = 2'b10;
  localparam logic [1:0] TAP_B4 = 2'b11;
  localparam int CSUM_W = 8;
  function automatic logic [2:0] tap_idx(input logic [1:0] sel);
    case (sel)
      TAP_B7: tap_idx = 3'd7;
      TAP_B6: tap_idx = 3'd6;
      TAP_B5: tap_idx = 3'd5;
      TAP_B4: tap_idx = 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/mdl_bdocsum.sv
// mdl_bdocsum: serial end-around-carry checksum accumulator with LSB-first shift-out
module mdl_bdocsum
  import mdl_bdoscrgen_pkg::*;
(
  input  logic i_MCLK,
  input  logic i_SYS_RST,
  input  logic i_CLR,
  input  logic i_EN,
  input  logic i_SHIFT,
  input  logic i_BIT,
  output logic o_LSB
);
  logic [CSUM_W-1:0] acc;
  logic carry;
  logic sum;
  assign sum = i_BIT ^ acc[0] ^ carry;
  assign o_LSB = acc[0];
  // Carry persists across byte boundaries so the byte-7 carry wraps into the next byte's bit 0
  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST || i_CLR) begin
      acc <= '0;
      carry <= 1'b0;
    end else if (i_EN) begin
      acc <= {sum, acc[CSUM_W-1:1]};
      carry <= (i_BIT & acc[0]) | (carry & (i_BIT ^ acc[0]));
    end else if (i_SHIFT) begin
      acc <= {1'b0, acc[CSUM_W-1:1]};
    end
  end
endmodule

// File: rtl/mdl_bdoscrgen.sv
// mdl_bdoscrgen: bubble data output page serialiser with mask scrambling; checksum tail under BDOSCR_CHECKSUM_EN
module mdl_bdoscrgen
  import mdl_bdoscrgen_pkg::*;
#(
  parameter int PAGE_BITS = 512
) (
  input  logic       i_MCLK,
  input  logic       i_SYS_RST,
  input  logic       i_CLK2M_PCEN_n,
  input  logic       i_PAGE_START,
  input  logic       i_BOOT,
  input  logic       i_SCR_EN,
  input  logic [1:0] i_PG_SEL,
  input  logic [7:0] i_SEED,
  input  logic       i_BIT_TICK,
  input  logic       i_DATA,
  output logic       o_DATA_RD,
  output logic       o_BDO,
  output logic       o_BDO_EN,
  output logic       o_BUSY,
  output logic       o_DONE
);
  localparam int CW = $clog2(PAGE_BITS);
  state_t state;
  state_t nxt;
  state_t after_data;
  logic [CW-1:0] cnt;
  logic [7:0] mask;
  logic [2:0] tap;
  logic boot;
  logic scr_en;
  logic ce;
  logic start;
  logic data_tick;
  logic last_data;
  logic csum_done;
  logic data_bit;
  logic out_bit;
  logic emit;
  assign ce = ~i_CLK2M_PCEN_n;
  assign start = ce & i_PAGE_START;
  assign data_tick = ce & i_BIT_TICK & (state == DATA);
  assign last_data = cnt == CW'(PAGE_BITS - 1);
  assign data_bit = i_DATA ^ (mask[tap] & ~boot & scr_en);
`ifdef BDOSCR_CHECKSUM_EN
  logic csum_tick;
  logic csum_lsb;
  assign csum_tick = ce & i_BIT_TICK & (state == CSUM);
  assign csum_done = csum_tick & (cnt[2:0] == 3'd7);
  assign after_data = boot ? CSUM : FIN;
  assign out_bit = state == CSUM ? csum_lsb : data_bit;
  assign emit = (data_tick | csum_tick) & ~start;
  mdl_bdocsum u_csum (
    .i_MCLK    (i_MCLK),
    .i_SYS_RST (i_SYS_RST),
    .i_CLR     (start),
    .i_EN      (data_tick & boot & ~start),
    .i_SHIFT   (csum_tick & ~start),
    .i_BIT     (i_DATA),
    .o_LSB     (csum_lsb)
  );
`else
  assign csum_done = 1'b1;
  assign after_data = FIN;
  assign out_bit = data_bit;
  assign emit = data_tick & ~start;
`endif
  // State register; reset wins over the clock enable
  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) state <= IDLE;
    else state <= nxt;
  end
  // Next state; a start pulse restarts from any state, including the FIN cycle
  always_comb begin
    nxt = start ? DATA :
          ~ce ? state :
          (state == IDLE || state == FIN) ? IDLE :
          state == DATA ? ((data_tick && last_data) ? after_data : DATA) :
          (csum_done ? FIN : CSUM);
  end
  // Outputs decoded from the current state
  always_comb begin
    o_DATA_RD = data_tick;
    o_BUSY = state != IDLE;
    o_DONE = state == FIN;
  end
  // Page setup, mask rotation, bit counting and the registered output bit
  always_ff @(posedge i_MCLK) begin
    if (i_SYS_RST) begin
      mask <= '0;
      boot <= 1'b0;
      scr_en <= 1'b0;
      tap <= 3'd7;
      cnt <= '0;
      o_BDO <= 1'b0;
      o_BDO_EN <= 1'b0;
    end else if (ce) begin
      o_BDO_EN <= emit;
      if (emit) o_BDO <= out_bit;
      if (start) begin
        boot <= i_BOOT;
        scr_en <= i_SCR_EN;
        tap <= tap_idx(i_PG_SEL);
        mask <= i_SEED;
        cnt <= '0;
      end else if (data_tick) begin
        mask <= {mask[0], mask[7:1]};
        cnt <= last_data ? '0 : cnt + CW'(1);
      end
`ifdef BDOSCR_CHECKSUM_EN
      else if (csum_tick) cnt <= cnt + CW'(1);
`endif
    end
  end
endmodule

// File: tb/tb_mdl_bdoscrgen.sv
// tb_mdl_bdoscrgen: directed self-checking bench for mdl_bdoscrgen (tail checks follow BDOSCR_CHECKSUM_EN)
module tb_mdl_bdoscrgen;
  localparam int PB = 512;
`ifdef BDOSCR_CHECKSUM_EN
  localparam bit TAIL = 1'b1;
`else
  localparam bit TAIL = 1'b0;
`endif
  logic i_MCLK = 1'b0;
  logic i_SYS_RST = 1'b1;
  logic i_CLK2M_PCEN_n = 1'b0;
  logic i_PAGE_START = 1'b0;
  logic i_BOOT = 1'b0;
  logic i_SCR_EN = 1'b0;
  logic [1:0] i_PG_SEL = 2'b00;
  logic [7:0] i_SEED = 8'h00;
  logic i_BIT_TICK = 1'b0;
  logic i_DATA = 1'b0;
  logic o_DATA_RD, o_BDO, o_BDO_EN, o_BUSY, o_DONE;
  int total = 0;
  int bad = 0;
  int mism = 0;
  logic [7:0] seq_a5 = 8'h4B;
  logic [7:0] seq_0f = 8'h1E;
  logic [7:0] seq_a5_t4 = 8'h5A;
  mdl_bdoscrgen #(.PAGE_BITS(PB)) dut (
    .i_MCLK         (i_MCLK),
    .i_SYS_RST      (i_SYS_RST),
    .i_CLK2M_PCEN_n (i_CLK2M_PCEN_n),
    .i_PAGE_START   (i_PAGE_START),
    .i_BOOT         (i_BOOT),
    .i_SCR_EN       (i_SCR_EN),
    .i_PG_SEL       (i_PG_SEL),
    .i_SEED         (i_SEED),
    .i_BIT_TICK     (i_BIT_TICK),
    .i_DATA         (i_DATA),
    .o_DATA_RD      (o_DATA_RD),
    .o_BDO          (o_BDO),
    .o_BDO_EN       (o_BDO_EN),
    .o_BUSY         (o_BUSY),
    .o_DONE         (o_DONE)
  );
  always #5 i_MCLK = ~i_MCLK;
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge i_MCLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_bit(input logic d, input logic exp_b);
    i_BIT_TICK = 1'b1;
    i_DATA = d;
    #1;
    if (o_DATA_RD !== 1'b1) mism++;
    step();
    if (o_BDO_EN !== 1'b1 || o_BDO !== exp_b) mism++;
  endtask
  task automatic start_page(input string tag, input logic boot, input logic scr, input logic [1:0] sel, input logic [7:0] seed);
    i_BOOT = boot;
    i_SCR_EN = scr;
    i_PG_SEL = sel;
    i_SEED = seed;
    i_BIT_TICK = 1'b0;
    i_PAGE_START = 1'b1;
    step();
    i_PAGE_START = 1'b0;
    chk({tag, "_start"}, {o_BUSY, o_DONE, o_BDO_EN}, 3'b100);
  endtask
  task automatic run_page(input string tag, input logic boot, input logic scr, input logic [1:0] sel, input logic [7:0] seed,
                          input logic [7:0] dbyte, input logic [7:0] xseq, input logic [7:0] csum, input bit tail);
    start_page(tag, boot, scr, sel, seed);
    mism = 0;
    for (int i = 0; i < PB; i++) begin
      do_bit(dbyte[i % 8], dbyte[i % 8] ^ xseq[i % 8]);
      if (i < PB - 1 && (o_DONE !== 1'b0 || o_BUSY !== 1'b1)) mism++;
    end
    chk({tag, "_data"}, mism, 0);
    if (tail) begin
      mism = 0;
      for (int i = 0; i < 8; i++) begin
        i_BIT_TICK = 1'b1;
        #1;
        if (o_DATA_RD !== 1'b0) mism++;
        step();
        if (o_BDO_EN !== 1'b1 || o_BDO !== csum[i]) mism++;
        if (i < 7 && o_DONE !== 1'b0) mism++;
      end
      chk({tag, "_tail"}, mism, 0);
    end
    chk({tag, "_done"}, o_DONE, 1);
    i_BIT_TICK = 1'b1;
    #1;
    chk({tag, "_fin_rd"}, o_DATA_RD, 0);
    step();
    i_BIT_TICK = 1'b0;
    chk({tag, "_idle"}, {o_BUSY, o_DONE, o_BDO_EN}, 3'b000);
  endtask
  initial begin
    step();
    step();
    chk("reset_out", {o_BDO, o_BDO_EN, o_BUSY, o_DONE}, 4'b0000);
    i_SYS_RST = 1'b0;
    i_BIT_TICK = 1'b1;
    #1;
    chk("idle_rd", o_DATA_RD, 0);
    step();
    chk("idle_tick", {o_BUSY, o_BDO_EN}, 2'b00);
    start_page("rst", 1'b0, 1'b1, 2'b00, 8'hA5);
    mism = 0;
    for (int i = 0; i < 100; i++) do_bit(1'b0, seq_a5[i % 8]);
    chk("pre_rst", mism, 0);
    i_CLK2M_PCEN_n = 1'b1;
    i_SYS_RST = 1'b1;
    step();
    chk("rst_mid", {o_BUSY, o_BDO_EN, o_DONE, o_BDO}, 4'b0000);
    i_SYS_RST = 1'b0;
    i_CLK2M_PCEN_n = 1'b0;
    i_BIT_TICK = 1'b0;
    step();
    run_page("fresh", 1'b0, 1'b0, 2'b00, 8'hA5, 8'h5A, 8'h00, 8'h00, 1'b0);
    run_page("scr_a5", 1'b0, 1'b1, 2'b00, 8'hA5, 8'h00, seq_a5, 8'h00, 1'b0);
    run_page("scr_off", 1'b0, 1'b0, 2'b00, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0);
    run_page("tap4", 1'b0, 1'b1, 2'b11, 8'hA5, 8'hFF, seq_a5_t4, 8'h00, 1'b0);
    run_page("boot01", 1'b1, 1'b1, 2'b00, 8'hA5, 8'h01, 8'h00, 8'h40, TAIL);
    run_page("bootff", 1'b1, 1'b0, 2'b00, 8'h00, 8'hFF, 8'h00, 8'hFE, TAIL);
    start_page("hold", 1'b0, 1'b1, 2'b00, 8'hA5);
    mism = 0;
    for (int i = 0; i < 5; i++) do_bit(1'b0, seq_a5[i]);
    chk("hold_pre", mism, 0);
    i_CLK2M_PCEN_n = 1'b1;
    i_BIT_TICK = 1'b1;
    i_DATA = 1'b1;
    i_PAGE_START = 1'b1;
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (o_DATA_RD !== 1'b0) mism++;
      step();
      if (o_BDO_EN !== 1'b1 || o_BDO !== seq_a5[4] || o_BUSY !== 1'b1 || o_DONE !== 1'b0) mism++;
    end
    chk("hold", mism, 0);
    i_PAGE_START = 1'b0;
    i_CLK2M_PCEN_n = 1'b0;
    mism = 0;
    for (int i = 5; i < PB; i++) begin
      do_bit(1'b0, seq_a5[i % 8]);
      if (i < PB - 1 && o_DONE !== 1'b0) mism++;
    end
    chk("hold_resume", mism, 0);
    i_BIT_TICK = 1'b0;
    chk("hold_done", o_DONE, 1);
    step();
    start_page("rs", 1'b0, 1'b1, 2'b00, 8'hA5);
    mism = 0;
    for (int i = 0; i < 37; i++) do_bit(1'b0, seq_a5[i % 8]);
    chk("rs_pre", mism, 0);
    start_page("rs_new", 1'b0, 1'b1, 2'b00, 8'h0F);
    mism = 0;
    for (int i = 0; i < PB; i++) begin
      do_bit(1'b0, seq_0f[i % 8]);
      if (i < PB - 1 && o_DONE !== 1'b0) mism++;
    end
    chk("rs_data", mism, 0);
    i_BIT_TICK = 1'b0;
    chk("rs_done", o_DONE, 1);
    i_SCR_EN = 1'b0;
    i_BOOT = 1'b0;
    i_PAGE_START = 1'b1;
    step();
    i_PAGE_START = 1'b0;
    chk("fin_start", {o_BUSY, o_DONE}, 2'b10);
    mism = 0;
    for (int i = 0; i < 3; i++) do_bit(1'b1, 1'b1);
    chk("fin_start_bits", mism, 0);
    i_BIT_TICK = 1'b0;
    i_SYS_RST = 1'b1;
    step();
    chk("final_rst", {o_BUSY, o_BDO_EN, o_DONE}, 3'b000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
